// File: rtl/servant_loader_pkg.sv
// -----------------------------------------------------------------------------
// servant_loader_pkg
// Shared definitions for the servant RAM loader: FSM state encoding, Wishbone
// byte-select constants and small arithmetic helpers used by the top level.
// -----------------------------------------------------------------------------
package servant_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Full-word byte enables while a bus cycle is active, none otherwise
  localparam logic [3:0] SEL_ALL  = 4'hF;
  localparam logic [3:0] SEL_NONE = 4'h0;

  // Running checksum step; wraps modulo 2^32
  function automatic logic [31:0] sum_add(input logic [31:0] acc,
                                          input logic [31:0] word);
    return acc + word;
  endfunction

  // States in which a load or verify is in progress
  function automatic logic is_busy(input state_e st);
    return (st == ST_COLLECT) || (st == ST_WRITE) || (st == ST_READ);
  endfunction

endpackage

// File: rtl/servant_loader_asm.sv
// -----------------------------------------------------------------------------
// servant_loader_asm
// Byte-to-word assembler. Bytes arrive least significant first and are shifted
// in from the top, so after four pushes the first byte sits in bits [7:0].
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   clr_i         synchronous clear of index, shift register and valid flag
//   push_i        accept byte_i this cycle
//   byte_i        stream byte
//   word_o        assembled word (shift register contents)
//   word_valid_o  a full word has been assembled since the last clear
//   last_o        the next push completes a word
// -----------------------------------------------------------------------------
module servant_loader_asm (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        last_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] sr_q,  sr_d;
  logic        vld_q, vld_d;

  // Next-state: clear wins over push; index wraps naturally after 4 bytes
  always_comb begin
    idx_d = idx_q;
    sr_d  = sr_q;
    vld_d = vld_q;
    if (clr_i) begin
      idx_d = 2'd0;
      sr_d  = 32'h0000_0000;
      vld_d = 1'b0;
    end else if (push_i) begin
      sr_d  = {byte_i, sr_q[31:8]};
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        vld_d = 1'b1;
      end else begin
        vld_d = vld_q;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Assembler state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= 2'd0;
      sr_q  <= 32'h0000_0000;
      vld_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      sr_q  <= sr_d;
      vld_q <= vld_d;
    end
  end

  assign word_o       = sr_q;
  assign word_valid_o = vld_q;
  assign last_o       = (idx_q == 2'd3);

endmodule

// File: rtl/servant_wb_loader.sv
// -----------------------------------------------------------------------------
// servant_wb_loader
// Wishbone initiator that fills the servant RAM from a byte stream, then reads
// every written word back and checksums it. The CPU is held in reset from
// power-up until a load/verify pass reaches DONE.
//
// Ports:
//   i_wb_clk, i_wb_rst_n   clock, asynchronous active-low reset
//   i_start, i_len         start pulse (sampled in IDLE/DONE) and word count
//   i_data, i_valid,       byte stream in; a byte is taken on i_valid & o_ready
//   o_ready
//   o_wb_*, i_wb_rdt,      classic single-word Wishbone initiator
//   i_wb_ack
//   o_busy                 load or verify in progress
//   o_cpu_hold             CPU reset request, low only in DONE
//   o_done, o_match,       completion, read-back == written, read-back sum
//   o_checksum
//
// Bus timing: each WRITE/READ word spends one cycle with cyc low before cyc is
// raised, and cyc drops on the edge that samples ack. Consecutive cycles are
// therefore always separated by an idle clock, which keeps a level-toggling
// acknowledge (ack <= cyc & !ack) from seeing cyc straddle an ack.
// -----------------------------------------------------------------------------
module servant_wb_loader
  import servant_loader_pkg::*;
#(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic          i_start,
  input  logic [aw-1:0] i_len,
  input  logic [7:0]    i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [31:2]   o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_busy,
  output logic          o_cpu_hold,
  output logic          o_done,
  output logic          o_match,
  output logic [31:0]   o_checksum
);

  localparam logic [aw-1:0] CNT_ONE = {{(aw-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [aw-1:0]   len_q, len_d;
  logic [aw-1:0]   cnt_q, cnt_d;
  logic [aw-1:0]   cnt_inc_s;
  logic [31:0]     wsum_q, wsum_d;
  logic [31:0]     rsum_q, rsum_d;

  logic            ready_q, ready_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:2]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic            busy_q, busy_d;
  logic            hold_q, hold_d;
  logic            done_q, done_d;
  logic            match_q, match_d;
  logic [31:0]     checksum_q, checksum_d;

  logic            byte_take_s;
  logic            asm_clr_s;
  logic [31:0]     asm_word_s;
  logic            asm_word_valid_s;
  logic            asm_last_s;

  assign byte_take_s = i_valid & ready_q;
  assign cnt_inc_s   = cnt_q + CNT_ONE;

  servant_loader_asm u_asm (
    .clk_i        (i_wb_clk),
    .rst_ni       (i_wb_rst_n),
    .clr_i        (asm_clr_s),
    .push_i       (byte_take_s),
    .byte_i       (i_data),
    .word_o       (asm_word_s),
    .word_valid_o (asm_word_valid_s),
    .last_o       (asm_last_s)
  );

  // FSM next-state, counters, sums and next values of every registered output
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wsum_d    = wsum_q;
    rsum_d    = rsum_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    asm_clr_s = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          len_d     = i_len;
          cnt_d     = '0;
          wsum_d    = 32'h0000_0000;
          rsum_d    = 32'h0000_0000;
          asm_clr_s = 1'b1;
          if (i_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_COLLECT: begin
        if (byte_take_s && asm_last_s) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_WRITE: begin
        if (!cyc_q) begin
          // Entry cycle: launch the write of the freshly assembled word
          if (asm_word_valid_s) begin
            cyc_d = 1'b1;
            we_d  = 1'b1;
            sel_d = SEL_ALL;
            adr_d = {{(30-aw){1'b0}}, cnt_q};
            dat_d = asm_word_s;
          end else begin
            cyc_d = 1'b0;
          end
        end else if (i_wb_ack) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          sel_d     = SEL_NONE;
          wsum_d    = sum_add(wsum_q, dat_q);
          asm_clr_s = 1'b1;
          if (cnt_inc_s == len_q) begin
            cnt_d   = '0;
            state_d = ST_READ;
          end else begin
            cnt_d   = cnt_inc_s;
            state_d = ST_COLLECT;
          end
        end else begin
          cyc_d = 1'b1;
        end
      end

      ST_READ: begin
        if (!cyc_q) begin
          // Idle clock after every ack, then the next read is launched
          cyc_d = 1'b1;
          we_d  = 1'b0;
          sel_d = SEL_ALL;
          adr_d = {{(30-aw){1'b0}}, cnt_q};
        end else if (i_wb_ack) begin
          cyc_d  = 1'b0;
          sel_d  = SEL_NONE;
          rsum_d = sum_add(rsum_q, i_wb_rdt);
          cnt_d  = cnt_inc_s;
          if (cnt_inc_s == len_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          cyc_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        sel_d   = SEL_NONE;
      end
    endcase

    // Status outputs follow the state being entered so they are registered
    // yet aligned with the state register.
    ready_d    = (state_d == ST_COLLECT);
    busy_d     = is_busy(state_d);
    done_d     = (state_d == ST_DONE);
    hold_d     = ~done_d;
    if (done_d) begin
      checksum_d = rsum_d;
      match_d    = (rsum_d == wsum_d);
    end else begin
      checksum_d = 32'h0000_0000;
      match_d    = 1'b0;
    end
  end

  // State, bookkeeping and output registers; reset aborts any bus cycle at once
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      wsum_q     <= 32'h0000_0000;
      rsum_q     <= 32'h0000_0000;
      ready_q    <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= SEL_NONE;
      adr_q      <= '0;
      dat_q      <= 32'h0000_0000;
      busy_q     <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      checksum_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wsum_q     <= wsum_d;
      rsum_q     <= rsum_d;
      ready_q    <= ready_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      busy_q     <= busy_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      match_q    <= match_d;
      checksum_q <= checksum_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_we    = we_q;
  assign o_wb_sel   = sel_q;
  assign o_wb_adr   = adr_q;
  assign o_wb_dat   = dat_q;
  assign o_busy     = busy_q;
  assign o_cpu_hold = hold_q;
  assign o_done     = done_q;
  assign o_match    = match_q;
  assign o_checksum = checksum_q;

endmodule

// File: tb/tb_servant_wb_loader.sv
// -----------------------------------------------------------------------------
// tb_servant_wb_loader
// Directed bench for servant_wb_loader with a RAM responder of configurable
// ack latency and a byte feeder with optional gaps. Expected bus traffic and
// sums are derived from the byte stream by a transaction-level model.
// -----------------------------------------------------------------------------
module tb_servant_wb_loader;

  typedef struct {
    bit          we;
    int          adr;
    logic [31:0] dat;
  } txn_t;

  logic        clk = 1'b0;
  logic        i_wb_rst_n;
  logic        i_start;
  logic [7:0]  i_len;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        o_ready;
  logic [31:2] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        o_busy;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_match;
  logic [31:0] o_checksum;

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  bit          gap_en = 1'b0;
  bit          mem_fill = 1'b0;
  int          ack_dly = 0;
  int          wait_cnt = 0;
  int          cyc_total = 0;
  logic [31:0] rd_xor = 32'h0;
  logic [31:0] mem [128];
  logic [7:0]  bytes [256];
  logic [7:0]  byte_q [$];
  txn_t        exp_q [$];
  logic [31:0] exp_sum;
  bit          exp_match;
  bit          prev_cyc = 1'b0;
  bit          prev_ack = 1'b0;

  always #5 clk = ~clk;

  servant_wb_loader dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (i_wb_rst_n),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_wb_adr   (o_wb_adr),
    .o_wb_dat   (o_wb_dat),
    .o_wb_sel   (o_wb_sel),
    .o_wb_we    (o_wb_we),
    .o_wb_cyc   (o_wb_cyc),
    .i_wb_rdt   (i_wb_rdt),
    .i_wb_ack   (i_wb_ack),
    .o_busy     (o_busy),
    .o_cpu_hold (o_cpu_hold),
    .o_done     (o_done),
    .o_match    (o_match),
    .o_checksum (o_checksum)
  );

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // RAM responder: ack after ack_dly cycles of cyc, read data optionally corrupted
  assign i_wb_ack = o_wb_cyc && (wait_cnt == ack_dly);
  assign i_wb_rdt = mem[o_wb_adr[8:2]] ^ rd_xor;

  always @(posedge clk) begin
    if (o_wb_cyc && !i_wb_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
    if (mem_fill) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hA5A5_0000 + 32'(i);
    end else if (o_wb_cyc && i_wb_ack && o_wb_we) begin
      mem[o_wb_adr[8:2]] <= o_wb_dat;
    end
  end

  // Compare process: bus protocol rules, status relations, expected transactions
  always @(negedge clk) begin
    if (i_wb_rst_n && chk_en) begin
      check("sel_rule", {28'h0, o_wb_sel}, o_wb_cyc ? 32'hF : 32'h0);
      check("hold_is_not_done", {31'h0, o_cpu_hold}, {31'h0, ~o_done});
      check("busy_and_done", {31'h0, o_busy & o_done}, 32'h0);
      check("cyc_without_busy", {31'h0, o_wb_cyc & ~o_busy}, 32'h0);
      check("ready_during_cyc", {31'h0, o_ready & o_wb_cyc}, 32'h0);
      if (prev_ack) check("gap_after_ack", {31'h0, o_wb_cyc}, 32'h0);
      if (prev_cyc && !prev_ack) check("cyc_held_to_ack", {31'h0, o_wb_cyc}, 32'h1);
      if (o_wb_cyc) cyc_total <= cyc_total + 1;
      if (o_wb_cyc && i_wb_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected actual=cycle adr %h required=no cycle",
                   o_wb_adr);
        end else begin
          check("bus_we", {31'h0, o_wb_we}, {31'h0, exp_q[0].we});
          check("bus_adr", {2'b00, o_wb_adr}, exp_q[0].adr);
          if (exp_q[0].we) check("bus_dat", o_wb_dat, exp_q[0].dat);
          void'(exp_q.pop_front());
        end
      end
      prev_cyc <= o_wb_cyc;
      prev_ack <= o_wb_cyc & i_wb_ack;
    end else begin
      prev_cyc <= 1'b0;
      prev_ack <= 1'b0;
    end
  end

  // Byte feeder: offers the queue head, pops it once accepted
  initial begin
    bit take;
    i_valid = 1'b0;
    i_data  = 8'h00;
    forever begin
      @(negedge clk);
      take = i_valid && o_ready && i_wb_rst_n;
      @(posedge clk);
      if (take && byte_q.size() > 0) void'(byte_q.pop_front());
      #1;
      if (byte_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        i_valid = 1'b1;
        i_data  = byte_q[0];
      end else begin
        i_valid = 1'b0;
      end
    end
  end

  // Model: words from bytes (little-endian), expected writes then reads, sum
  task automatic queue_load(input int n);
    logic [31:0] w;
    txn_t t;
    exp_sum = 32'h0;
    for (int i = 0; i < n; i++) begin
      w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
      for (int b = 0; b < 4; b++) byte_q.push_back(bytes[4*i+b]);
      t.we = 1'b1; t.adr = i; t.dat = w;
      exp_q.push_back(t);
      exp_sum = exp_sum + (w ^ rd_xor);
    end
    for (int i = 0; i < n; i++) begin
      t.we = 1'b0; t.adr = i; t.dat = 32'h0;
      exp_q.push_back(t);
    end
    exp_match = (n == 0) || (rd_xor == 32'h0);
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_len   = 8'(n);
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Wait (bounded) for DONE, counting edges from the start edge
  task automatic finish_load(input string nm, input int exp_cycles, input bit poke);
    int cycles;
    bit poked;
    cycles = 1;
    poked  = 1'b0;
    while (!o_done && cycles < 5000) begin
      if (poke && !poked && o_wb_cyc && o_wb_we) begin
        i_start = 1'b1;
        i_len   = 8'd1;
        poked   = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    i_start = 1'b0;
    check({nm, "_done"}, {31'h0, o_done}, 32'h1);
    if (exp_cycles > 0) check({nm, "_cycles"}, cycles, exp_cycles);
    if (poke) check({nm, "_poked"}, {31'h0, poked}, 32'h1);
    check({nm, "_checksum"}, o_checksum, exp_sum);
    check({nm, "_match"}, {31'h0, o_match}, {31'h0, exp_match});
    check({nm, "_txn_left"}, exp_q.size(), 32'h0);
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_ready"},    {31'h0, o_ready},    32'h0);
    check({nm, "_cyc"},      {31'h0, o_wb_cyc},   32'h0);
    check({nm, "_we"},       {31'h0, o_wb_we},    32'h0);
    check({nm, "_sel"},      {28'h0, o_wb_sel},   32'h0);
    check({nm, "_adr"},      {2'b00, o_wb_adr},   32'h0);
    check({nm, "_dat"},      o_wb_dat,            32'h0);
    check({nm, "_busy"},     {31'h0, o_busy},     32'h0);
    check({nm, "_done"},     {31'h0, o_done},     32'h0);
    check({nm, "_match"},    {31'h0, o_match},    32'h0);
    check({nm, "_checksum"}, o_checksum,          32'h0);
    check({nm, "_hold"},     {31'h0, o_cpu_hold}, 32'h1);
  endtask

  initial begin
    int cyc_before;
    int waited;
    logic [7:0] t1 [8];
    t1 = '{8'h13, 8'h04, 8'h10, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
    i_wb_rst_n = 1'b0;
    i_start    = 1'b0;
    i_len      = 8'h00;
    mem_fill   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    mem_fill   = 1'b0;
    i_wb_rst_n = 1'b1;
    chk_en     = 1'b1;
    @(posedge clk); #1;

    // Two-word load from the literal stream, minimum timing 8N+1
    for (int k = 0; k < 8; k++) bytes[k] = t1[k];
    queue_load(2);
    pulse_start(2);
    finish_load("basic", 17, 1'b0);
    check("basic_sum_literal", o_checksum, 32'h0020_0486);
    check("basic_mem0", mem[0], 32'h0010_0413);
    check("basic_mem1", mem[1], 32'h0010_0073);

    // Zero-length load goes straight to DONE with no bus cycle
    cyc_before = cyc_total;
    queue_load(0);
    pulse_start(0);
    finish_load("len0", 1, 1'b0);
    check("len0_checksum_literal", o_checksum, 32'h0);
    check("len0_no_cyc", cyc_total, cyc_before);

    // Stream gaps and a slow (3-cycle) acknowledge
    gap_en  = 1'b1;
    ack_dly = 3;
    for (int k = 0; k < 20; k++) bytes[k] = 8'($urandom_range(0, 255));
    queue_load(5);
    pulse_start(5);
    finish_load("gaps_slowack", 0, 1'b0);
    gap_en  = 1'b0;
    ack_dly = 0;

    // Full RAM: 64 words of incrementing bytes, last address 63
    for (int k = 0; k < 256; k++) bytes[k] = 8'(k);
    queue_load(64);
    pulse_start(64);
    finish_load("full", 513, 1'b0);
    check("full_mem63", mem[63], 32'hFFFE_FDFC);
    check("full_mem64_untouched", mem[64], 32'hA5A5_0040);

    // Start pulsed during WRITE is ignored
    ack_dly = 1;
    for (int k = 0; k < 8; k++) bytes[k] = 8'($urandom_range(0, 255));
    queue_load(2);
    pulse_start(2);
    finish_load("poke", 0, 1'b1);

    // Restart from DONE with one word: hold reasserts, adr 0 rewritten
    bytes[0] = 8'hEF; bytes[1] = 8'hBE; bytes[2] = 8'hAD; bytes[3] = 8'hDE;
    queue_load(1);
    pulse_start(1);
    check("restart_hold", {31'h0, o_cpu_hold}, 32'h1);
    check("restart_done_low", {31'h0, o_done}, 32'h0);
    finish_load("restart", 0, 1'b0);
    check("restart_mem0", mem[0], 32'hDEAD_BEEF);
    ack_dly = 0;

    // Corrupted read-back must clear o_match
    rd_xor   = 32'h0000_0100;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04;
    queue_load(1);
    pulse_start(1);
    finish_load("corrupt", 0, 1'b0);
    check("corrupt_sum_literal", o_checksum, 32'h0403_0301);
    rd_xor = 32'h0;

    // Reset while a write cycle is in flight
    ack_dly = 2;
    for (int k = 0; k < 12; k++) bytes[k] = 8'(8'h40 + k);
    queue_load(3);
    pulse_start(3);
    waited = 0;
    while (!(o_wb_cyc && o_wb_we) && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("rst_reached_write", {31'h0, o_wb_cyc & o_wb_we}, 32'h1);
    @(negedge clk); #2;
    i_wb_rst_n = 1'b0;
    #1;
    check("rst_async_cyc", {31'h0, o_wb_cyc}, 32'h0);
    check_reset_values("midreset");
    byte_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    i_wb_rst_n = 1'b1;
    ack_dly = 0;
    for (int k = 0; k < 8; k++) bytes[k] = 8'(8'h90 + 3 * k);
    queue_load(2);
    pulse_start(2);
    finish_load("after_reset", 17, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
